// File: rtl/ebpc_pkg.sv
// ebpc_pkg: shared widths and the delta bit-plane block type of the EBPC codec.
package ebpc_pkg;
    localparam int DATA_W     = 8;
    localparam int BLOCK_SIZE = 8;
    localparam int CNT_W      = $clog2(DATA_W + 1);
    localparam int PAD_W      = DATA_W - BLOCK_SIZE + 1;

    typedef struct packed {
        logic [DATA_W-1:0]                 base;
        logic [DATA_W:0][BLOCK_SIZE-2:0]   dbp;
    } dbp_block_t;
endpackage

// File: rtl/dbp_serializer.sv
// dbp_serializer: streams one dbp_block_t as its base word followed by the
// DATA_W+1 bit-planes, dbp[0] first, each beat tagged for the ZRLE stage.
module dbp_serializer
    import ebpc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  dbp_block_t        data_i,
    input  logic              vld_i,
    output logic              rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              base_o,
    output logic              zero_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i,
    input  logic              clr_i
);
    typedef enum logic [1:0] {S_IDLE, S_BASE, S_PLANES} ser_state_t;

    ser_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dbp_block_t       blk_q, blk_d;
    logic             at_last;

    assign at_last = cnt_q == CNT_W'(DATA_W);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        rdy_o   = 1'b0;
        vld_o   = 1'b0;
        data_o  = '0;
        base_o  = 1'b0;
        zero_o  = 1'b0;
        last_o  = 1'b0;
        if (clr_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            blk_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rdy_o = 1'b1;
                    if (vld_i) begin
                        blk_d   = data_i;
                        state_d = S_BASE;
                    end
                end
                S_BASE: begin
                    vld_o  = 1'b1;
                    data_o = blk_q.base;
                    base_o = 1'b1;
                    if (rdy_i) begin
                        cnt_d   = '0;
                        state_d = S_PLANES;
                    end
                end
                S_PLANES: begin
                    vld_o  = 1'b1;
                    data_o = {blk_q.dbp[cnt_q], {PAD_W{1'b0}}};
                    zero_o = blk_q.dbp[cnt_q] == '0;
                    last_o = at_last;
                    // Final beat doubles as the accept slot for the next block.
                    if (rdy_i && at_last) begin
                        rdy_o   = vld_i;
                        blk_d   = vld_i ? data_i : blk_q;
                        state_d = vld_i ? S_BASE : S_IDLE;
                    end else if (rdy_i) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbp_serializer.sv
// tb_dbp_serializer: directed checks of block serialization, handshakes,
// backpressure, soft clear and asynchronous reset.
module tb_dbp_serializer;
    import ebpc_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    dbp_block_t        data_i = '0;
    logic              vld_i = 1'b0;
    logic              rdy_o;
    logic [DATA_W-1:0] data_o;
    logic              base_o, zero_o, last_o, vld_o;
    logic              rdy_i = 1'b0;
    logic              clr_i = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    typedef logic [7:0] words_t [10];
    localparam words_t WA = '{8'hA5, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h00};
    localparam words_t WB = '{8'h3C, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h00, 8'hAA};

    dbp_block_t blk_a, blk_b;

    dbp_serializer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .vld_i(vld_i), .rdy_o(rdy_o),
        .data_o(data_o), .base_o(base_o), .zero_o(zero_o), .last_o(last_o),
        .vld_o(vld_o), .rdy_i(rdy_i), .clr_i(clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input dbp_block_t blk, input bit keep);
        data_i = blk;
        vld_i  = 1'b1;
        #1;
        check("rdy_idle", 32'(rdy_o), 32'd1);
        tick();
        if (!keep) vld_i = 1'b0;
        check("base_latency", 32'(vld_o), 32'd1);
    endtask

    task automatic recv(input words_t w, input bit rnd);
        int k = 0;
        int cyc = 0;
        while (k < 10 && cyc < 400) begin
            rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("vld", 32'(vld_o), 32'd1);
            check($sformatf("data[%0d]", k), 32'(data_o), 32'(w[k]));
            check("base_flag", 32'(base_o), 32'(k == 0));
            check("zero_flag", 32'(zero_o), 32'(k != 0 && w[k] == 8'h00));
            check("last_flag", 32'(last_o), 32'(k == 9));
            if (rdy_i) begin
                check("rdy_beat", 32'(rdy_o), k == 9 ? 32'(vld_i) : 32'd0);
                k++;
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        if (k < 10) check("beat_timeout", 32'(k), 32'd10);
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, "_rdy"}, 32'(rdy_o), 32'd1);
        check({tag, "_vld"}, 32'(vld_o), 32'd0);
        check({tag, "_data"}, 32'(data_o), 32'd0);
        check({tag, "_flags"}, {29'd0, base_o, zero_o, last_o}, 32'd0);
    endtask

    initial begin
        blk_a = '0;
        blk_b = '0;
        blk_a.base = 8'hA5;
        for (int i = 0; i < 8; i++) blk_a.dbp[i] = 7'(i + 1);
        blk_b.base = 8'h3C;
        for (int i = 0; i < 7; i++) blk_b.dbp[i] = 7'(7'h40 >> i);
        blk_b.dbp[8] = 7'h55;

        #2;
        check_idle("reset");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        check_idle("post_reset");

        send(blk_a, 1'b0);
        recv(WA, 1'b0);
        check_idle("single_done");

        send(blk_a, 1'b1);
        data_i = blk_b;
        recv(WA, 1'b0);
        vld_i = 1'b0;
        recv(WB, 1'b0);
        check_idle("b2b_done");

        send(blk_a, 1'b0);
        recv(WA, 1'b1);
        rdy_i = 1'b0;
        check_idle("bp_done");
        send(blk_b, 1'b0);
        recv(WB, 1'b1);
        rdy_i = 1'b0;
        check_idle("bp_b_done");

        send(blk_a, 1'b0);
        rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("clr_pre_data", 32'(data_o), 32'h08);
        clr_i = 1'b1;
        #1;
        check("clr_vld", 32'(vld_o), 32'd0);
        check("clr_rdy", 32'(rdy_o), 32'd0);
        tick();
        clr_i = 1'b0;
        check_idle("clr_after");
        send(blk_b, 1'b0);
        recv(WB, 1'b0);

        send(blk_a, 1'b0);
        rdy_i = 1'b1;
        tick();
        tick();
        #1;
        check("rst_pre_data", 32'(data_o), 32'h04);
        rst_ni = 1'b0;
        check_idle("async_rst");
        tick();
        rst_ni = 1'b1;
        tick();
        check_idle("rst_release");
        send(blk_b, 1'b0);
        recv(WB, 1'b0);
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
